// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ysyx_23060332_ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    // One instruction in flight: fetch address, wait for data, hand off, wait for retire.
    typedef enum logic [2:0] {
        IfuIdle  = 3'd0,
        IfuAr    = 3'd1,
        IfuR     = 3'd2,
        IfuOut   = 3'd3,
        IfuWaitC = 3'd4
    } ifu_state_e;

    // Instructions are word aligned; the low two bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// Fetch-unit bus: instruction-memory read channel, decode handshake and commit feedback.
interface ysyx_23060332_ifu_if;

    // Instruction memory read channel
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    // Decode handshake
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid;
    logic        inst_ready;

    // Retire feedback
    logic        commit_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;

    logic        fetch_err;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output inst_o, inst_addr_o, inst_valid,
        input  inst_ready,
        input  commit_i, jump_flag_i, jump_addr_i,
        output fetch_err
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  inst_o, inst_addr_o, inst_valid,
        output inst_ready,
        output commit_i, jump_flag_i, jump_addr_i,
        input  fetch_err
    );

endinterface

// File: rtl/ysyx_23060332_ifu_pc.sv
// Architectural PC register with sequential increment and redirect.
module ysyx_23060332_ifu_pc
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic [31:0] pc,
    output logic        misalign
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: redirect to the aligned target, else step one word (wraps at 2^32).
    always_comb begin
        pc_d = pc_q;
        if (update) begin
            pc_d = jump_flag ? word_align(jump_addr) : pc_q + 32'd4;
        end
    end

    // Flag a redirect whose target is not word aligned.
    always_comb begin
        misalign = update & jump_flag & (jump_addr[1:0] != 2'b00);
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: fetches one instruction, hands it to decode, waits for its commit.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_23060332_ifu_if.master  bus
);

    ifu_state_e  state_q;
    ifu_state_e  state_d;
    logic [31:0] inst_buf_q;
    logic        fetch_err_q;
    logic [31:0] pc;
    logic        pc_update;
    logic        pc_misalign;
    logic        resp_bad;

    // Commit is only honoured once decode has taken the instruction.
    assign pc_update = bus.commit_i &
                       (((state_q == IfuOut) & bus.inst_ready) | (state_q == IfuWaitC));

    assign resp_bad = (state_q == IfuR) & bus.rvalid & (bus.rresp != RESP_OKAY);

    ysyx_23060332_ifu_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .update    (pc_update),
        .jump_flag (bus.jump_flag_i),
        .jump_addr (bus.jump_addr_i),
        .pc        (pc),
        .misalign  (pc_misalign)
    );

    // State register; reset abandons any outstanding fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IfuIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IfuIdle:  state_d = IfuAr;
            IfuAr:    if (bus.arready) state_d = IfuR;
            IfuR:     if (bus.rvalid) state_d = IfuOut;
            IfuOut: begin
                if (bus.inst_ready) begin
                    // A same-cycle commit skips the wait state entirely.
                    state_d = bus.commit_i ? IfuAr : IfuWaitC;
                end
            end
            IfuWaitC: if (bus.commit_i) state_d = IfuAr;
            default:  state_d = IfuIdle;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.arvalid     = (state_q == IfuAr);
        bus.rready      = (state_q == IfuR);
        bus.inst_valid  = (state_q == IfuOut);
        bus.araddr      = pc;
        bus.inst_o      = inst_buf_q;
        bus.inst_addr_o = pc;
        bus.fetch_err   = fetch_err_q;
    end

    // Instruction buffer; an error response delivers a NOP instead of the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_buf_q <= 32'h0;
        end else if ((state_q == IfuR) && bus.rvalid) begin
            inst_buf_q <= resp_bad ? NOP_INST : bus.rdata;
        end
    end

    // Sticky error flag: bad response or misaligned redirect, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err_q <= 1'b0;
        end else if (resp_bad || pc_misalign) begin
            fetch_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Self-checking bench for the fetch unit: transaction-level PC/error model, random delays.
module tb_ysyx_23060332_ifu;
    import ysyx_23060332_ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ysyx_23060332_ifu_if bus ();

    ysyx_23060332_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state: next fetch address and sticky error.
    logic [31:0] m_pc;
    logic        m_err;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.arready     = 1'b0;
        bus.rvalid      = 1'b0;
        bus.rdata       = 32'h0;
        bus.rresp       = 2'b00;
        bus.inst_ready  = 1'b0;
        bus.commit_i    = 1'b0;
        bus.jump_flag_i = 1'b0;
        bus.jump_addr_i = 32'h0;
    endtask

    // Hold reset over a clock edge, check reset outputs, release; returns at a negedge in AR.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk1("rst_arvalid", bus.arvalid, 1'b0);
        chk1("rst_rready", bus.rready, 1'b0);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk32("rst_inst_o", bus.inst_o, 32'h0);
        chk32("rst_inst_addr", bus.inst_addr_o, RST_PC);
        chk1("rst_fetch_err", bus.fetch_err, 1'b0);
        rst   = 1'b0;
        m_pc  = RST_PC;
        m_err = 1'b0;
        chk1("idle_arvalid", bus.arvalid, 1'b0);
        @(negedge clk);
    endtask

    // One full instruction lifetime. Entered and left at a negedge with the DUT in AR.
    task automatic fetch_one(input int ar_dly, input int r_dly, input int dec_dly,
                             input bit same, input int c_dly, input bit jump,
                             input logic [31:0] jaddr, input logic [1:0] resp,
                             input logic [31:0] data);
        logic [31:0] exp_inst;
        // Address phase; R-channel and commit activity here must be ignored.
        for (int i = 0; i <= ar_dly; i++) begin
            chk1("ar_arvalid", bus.arvalid, 1'b1);
            chk32("ar_araddr", bus.araddr, m_pc);
            chk1("ar_rready", bus.rready, 1'b0);
            chk1("ar_inst_valid", bus.inst_valid, 1'b0);
            bus.arready     = (i == ar_dly);
            bus.rvalid      = 1'($urandom_range(0, 1));
            bus.rdata       = $urandom;
            bus.rresp       = 2'($urandom_range(0, 3));
            bus.commit_i    = 1'($urandom_range(0, 1));
            bus.jump_flag_i = 1'($urandom_range(0, 1));
            bus.jump_addr_i = $urandom;
            @(negedge clk);
        end
        bus.arready = 1'b0;
        // Data phase.
        for (int i = 0; i <= r_dly; i++) begin
            chk1("r_arvalid", bus.arvalid, 1'b0);
            chk1("r_rready", bus.rready, 1'b1);
            chk1("r_inst_valid", bus.inst_valid, 1'b0);
            bus.rvalid      = (i == r_dly);
            bus.rdata       = (i == r_dly) ? data : $urandom;
            bus.rresp       = (i == r_dly) ? resp : 2'($urandom_range(0, 3));
            bus.commit_i    = 1'($urandom_range(0, 1));
            bus.jump_flag_i = 1'($urandom_range(0, 1));
            bus.jump_addr_i = $urandom;
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        exp_inst = (resp == 2'b00) ? data : NOP;
        if (resp != 2'b00) m_err = 1'b1;
        // Hand-off phase; commit without inst_ready must be ignored.
        for (int i = 0; i <= dec_dly; i++) begin
            chk1("out_inst_valid", bus.inst_valid, 1'b1);
            chk32("out_inst_o", bus.inst_o, exp_inst);
            chk32("out_inst_addr", bus.inst_addr_o, m_pc);
            chk1("out_arvalid", bus.arvalid, 1'b0);
            chk1("out_fetch_err", bus.fetch_err, m_err);
            bus.inst_ready = (i == dec_dly);
            if (i == dec_dly) begin
                bus.commit_i    = same;
                bus.jump_flag_i = jump;
                bus.jump_addr_i = jaddr;
            end else begin
                bus.commit_i    = 1'($urandom_range(0, 1));
                bus.jump_flag_i = 1'($urandom_range(0, 1));
                bus.jump_addr_i = $urandom;
            end
            @(negedge clk);
        end
        bus.inst_ready = 1'b0;
        bus.commit_i   = 1'b0;
        // Waiting for retirement; no new fetch may start.
        if (!same) begin
            for (int i = 0; i <= c_dly; i++) begin
                chk1("wc_arvalid", bus.arvalid, 1'b0);
                chk1("wc_inst_valid", bus.inst_valid, 1'b0);
                chk1("wc_rready", bus.rready, 1'b0);
                bus.commit_i    = (i == c_dly);
                bus.jump_flag_i = jump;
                bus.jump_addr_i = jaddr;
                @(negedge clk);
            end
            bus.commit_i = 1'b0;
        end
        // Model: redirect drops the low bits (flagging misalignment), else next word.
        if (jump) begin
            if (jaddr[1:0] != 2'b00) m_err = 1'b1;
            m_pc = {jaddr[31:2], 2'b00};
        end else begin
            m_pc = m_pc + 32'd4;
        end
        chk1("next_arvalid", bus.arvalid, 1'b1);
        chk32("next_araddr", bus.araddr, m_pc);
        chk1("next_fetch_err", bus.fetch_err, m_err);
    endtask

    initial begin
        logic [31:0] ja;
        logic [1:0]  rr;
        idle_inputs();
        do_reset();

        // Zero-wait fetch, sequential commit.
        fetch_one(0, 0, 0, 1'b0, 0, 1'b0, 32'h0, 2'b00, 32'h0010_0093);
        // Stalled memory and decode, then redirect to the last word.
        fetch_one(3, 0, 4, 1'b0, 2, 1'b1, 32'hFFFF_FFFC, 2'b00, 32'h1234_5678);
        // Same-cycle commit at the top of memory wraps to zero.
        fetch_one(0, 1, 0, 1'b1, 0, 1'b0, 32'h0, 2'b00, 32'hDEAD_BEEF);
        // Misaligned redirect.
        fetch_one(0, 0, 0, 1'b1, 0, 1'b1, 32'h8000_0102, 2'b00, 32'hCAFE_0001);
        // Error stays sticky.
        fetch_one(1, 1, 1, 1'b0, 1, 1'b0, 32'h0, 2'b00, 32'h0000_1111);

        // Error response delivers a NOP.
        do_reset();
        fetch_one(0, 2, 1, 1'b0, 0, 1'b0, 32'h0, 2'b10, 32'hABCD_EF01);

        // Reset while waiting in AR drops arvalid immediately.
        chk1("pre_rst_arvalid", bus.arvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("async_rst_arvalid", bus.arvalid, 1'b0);
        chk32("async_rst_araddr", bus.araddr, RST_PC);
        chk1("async_rst_fetch_err", bus.fetch_err, 1'b0);
        do_reset();

        // Randomised traffic.
        for (int n = 0; n < 30; n++) begin
            ja = $urandom;
            if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
            rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      ja, rr, $urandom);
            if (n == 14) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_ifu.md
Name: ysyx_23060332_ifu

Overview:
- Instruction fetch unit; sits directly upstream of the decode stage and feeds it the instruction word and its PC.
- Owns the architectural PC.
- Fetches from instruction memory over an AXI-lite-style read channel (AR/R).
- Presents each instruction to decode with a valid/ready handshake, then waits for a commit pulse carrying jump information before fetching the next instruction (multi-cycle, one instruction in flight).

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, word delivered in place of an instruction whose fetch returned an error response.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- araddr  out  32  fetch address (current PC).
- arvalid  out  1  read-address request valid.
- arready  in  1  memory accepts read address.
- rdata  in  32  returned instruction word.
- rresp  in  2  read response; 2'b00 = OKAY, anything else is an error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst_o  out  32  instruction to decode.
- inst_addr_o  out  32  PC of inst_o.
- inst_valid  out  1  inst_o/inst_addr_o valid.
- inst_ready  in  1  decode accepts instruction.
- commit_i  in  1  single-cycle pulse: current instruction has retired.
- jump_flag_i  in  1  qualified by commit_i; redirect to jump_addr_i.
- jump_addr_i  in  32  redirect target.
- fetch_err  out  1  sticky error flag (bad response or misaligned target).

Behaviour:
- Async reset clears state to IDLE, sets pc=RESET_PC, inst_buf=0 and fetch_err=0.
- Reset also forces arvalid=0, rready=0, inst_valid=0, inst_o=0 and inst_addr_o=RESET_PC.
- Reset mid-transaction drops arvalid/rready immediately (the only permitted AXI valid-drop) and abandons the fetch.
- FSM states: IDLE, AR, R, OUT, WAIT_C. Outputs are decoded from the registered state only; no combinational in-to-out paths.
- IDLE: go to AR unconditionally (first arvalid appears 1 cycle after reset release).
- AR: arvalid=1, araddr=pc, held stable until arready=1, then go to R. rvalid is ignored here (rready=0).
- R: rready=1; on rvalid, capture rdata into inst_buf, or NOP_INST if rresp!=0 (which also sets fetch_err); go to OUT.
- OUT: inst_valid=1, inst_o=inst_buf, inst_addr_o=pc, all held stable until inst_ready=1.
  - On inst_ready without commit_i: go to WAIT_C.
  - On inst_ready with commit_i in the same cycle: apply the PC update (below) and go straight to AR.
- WAIT_C: on commit_i, apply the PC update and go to AR.
- commit_i in IDLE, AR, R, or in OUT without inst_ready: ignored.
- PC update:
  - jump_flag_i=1: pc <= {jump_addr_i[31:2], 2'b00}; if jump_addr_i[1:0]!=0, set fetch_err.
  - jump_flag_i=0: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Latency: zero-wait memory gives arvalid->inst_valid = 2 cycles; per instruction = 3 cycles + decode/commit delay.
- fetch_err is cleared only by rst.

Decomposition:
- Shared define file additions: `IFU_IDLE/`IFU_AR/`IFU_R/`IFU_OUT/`IFU_WAIT_C (3-bit encodings), `RESP_OKAY 2'b00, `ResetPC. Reuse the existing `INST_NOP, `InstBus and `InstAddrBus.
- One natural sub-module: ysyx_23060332_ifu_pc, holding the PC register and next-PC logic (increment, redirect, alignment check).

Test Plan:
- Reset release, arready=rvalid=1 every cycle, rdata=32'h0010_0093 -> arvalid at cycle 1 with araddr=8000_0000; inst_valid at cycle 3 with inst_o=0010_0093 and inst_addr_o=8000_0000.
- commit_i with jump_flag_i=0 -> next araddr=8000_0004; with pc=FFFF_FFFC -> next araddr=0000_0000.
- commit_i with jump_flag_i=1 and jump_addr_i=8000_0102 -> araddr=8000_0100 and fetch_err=1, held until rst.
- arready delayed 3 cycles and inst_ready delayed 4 cycles -> araddr, arvalid, inst_o and inst_valid stay stable throughout; no extra fetch is issued.
- rresp=2'b10 -> inst_o=0000_0013 and fetch_err=1; pulse rst while in AR -> arvalid=0 in the same cycle, pc returns to 8000_0000.
- inst_ready and commit_i in the same OUT cycle -> WAIT_C is skipped; arvalid is asserted on the next cycle with the updated PC.
